baccarat_datapath: RTL and testbench
====================================

# baccarat_datapath

Card-handling datapath of the Baccarat game. It deals pseudo-random cards from a free-running 1..13 counter and latches them into six card registers (three player, three dealer) under controller load strobes. It computes the player and dealer Baccarat scores and drives six seven-segment displays showing the cards. It sits between the game state machine, which supplies the `load_*` strobes and consumes the scores and `pcard3_out`, and the board HEX displays.

## Interface
- No parameters.
- `fast_clock`  in  1  sole clock; all flops are rising-edge on it.
- `resetb`  in  1  reset, asynchronous, active-low.
- `slow_clock`  in  1  user "deal" button level. It is not a clock: it is sampled on `fast_clock`, and its rising edge is the load event.
- `load_pcard1`, `load_pcard2`, `load_pcard3`  in  1 each  load player card 1/2/3 on the load event.
- `load_dcard1`, `load_dcard2`, `load_dcard3`  in  1 each  load dealer card 1/2/3 on the load event.
- `pcard3_out`  out  4  raw value of player card 3 (0 = none, 1..13).
- `pscore_out`  out  4  player score, 0..9.
- `dscore_out`  out  4  dealer score, 0..9.
- `HEX0`, `HEX1`, `HEX2`  out  7 each  player cards 1/2/3; active-low, bit order {g,f,e,d,c,b,a}.
- `HEX3`, `HEX4`, `HEX5`  out  7 each  dealer cards 1/2/3; same format.

## Operation
- Card counter (4 bit):
  - reset value 1;
  - counts +1 every `fast_clock` edge;
  - wraps 13 -> 1 and never holds 0 or 14..15.
- Edge detect:
  - `slow_prev` flop holds the previous sample of `slow_clock`; reset value 0.
  - Load event = `slow_clock & ~slow_prev`, evaluated at a `fast_clock` edge.
- Card registers (six × 4 bit):
  - reset value 0 (no card);
  - on a load event, every register whose `load_*` is 1 at that same edge captures the current counter value;
  - several loads asserted together all capture the same value;
  - a `load_*` asserted without a load event does nothing;
  - registers otherwise hold.
- Card value for scoring: 1..9 -> face value; 0, 10, 11, 12, 13 -> 0.
- Scores:
  - `pscore_out` = (val(p1) + val(p2) + val(p3)) mod 10;
  - `dscore_out` = (val(d1) + val(d2) + val(d3)) mod 10;
  - the intermediate sum is at least 5 bits (max 27);
  - both scores are combinational from the registers.
- Seven-segment, combinational per card:
  - 0 -> 1111111 (blank)
  - 1 (A) -> 0001000
  - 2 -> 0100100
  - 3 -> 0110000
  - 4 -> 0011001
  - 5 -> 0010010
  - 6 -> 0000010
  - 7 -> 1111000
  - 8 -> 0000000
  - 9 -> 0010000
  - 10 -> 1000000
  - 11 (J) -> 1100001
  - 12 (Q) -> 0011000
  - 13 (K) -> 0001001
  - 14, 15 -> 1111111
- Reset mid-operation: all registers clear immediately; counter returns to 1.

## Timing
- Outputs after reset: all cards 0, `pscore_out` = 0, `dscore_out` = 0, `pcard3_out` = 0, all HEX = 1111111.
- Load latency: a card register updates at the first `fast_clock` edge at which `slow_clock` = 1 is seen with `slow_prev` = 0. Outputs reflect the new card combinationally after that edge.
- `slow_clock` and `load_*` must be stable together for at least one `fast_clock` rising edge.
- Holding `slow_clock` high for many cycles produces exactly one load.
- Captured value = counter value before that edge's increment.

## Configuration
- `SLOW_SYNC_EN`
  - Defined: `slow_clock` and all six `load_*` pass through a 2-flop synchronizer (reset 0) before edge detection. The load event and the loaded value are delayed by 2 `fast_clock` cycles, and the strobes stay aligned with the event.
  - Undefined: direct sampling as described above.

## Structure
- Package `baccarat_pkg` holds:
  - card constants: `CARD_NONE` = 0, `CARD_ACE` = 1, `CARD_KING` = 13;
  - the 14 seven-segment pattern constants;
  - a `card_value` function.
- Sub-module `card7seg` (4-bit card in -> 7-bit HEX out), instantiated six times.
- The counter, edge detect, registers and score adders stay in the top module.

## Test plan
- Reset held low -> all HEX = 1111111, scores 0, `pcard3_out` 0. Release reset and count edges -> counter sequence 1, 2, …, 13, 1.
- Pulse `slow_clock` with `load_pcard1` when counter = 7, then with `load_pcard2` when counter = 8 -> HEX0 = 1111000, HEX1 = 0000000, `pscore_out` = 5.
- Dealer loads K (13) then 5 -> HEX3 = 0001001, HEX4 = 0010010, `dscore_out` = 5.
- `load_pcard3` with counter = 12 -> `pcard3_out` = 12, HEX2 = 0011000, player score unchanged.
- Hold `slow_clock` high 5 cycles with `load_dcard3` -> exactly one capture. Assert a load without a `slow_clock` edge -> no change.
- Assert `resetb` = 0 after cards are loaded, asynchronously between clock edges -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/baccarat_pkg.sv
// Shared card constants, seven-segment patterns and scoring helpers
// for the Baccarat card datapath.
package baccarat_pkg;

  typedef logic [3:0] card_t;

  localparam int    NUM_CARDS = 6;
  localparam card_t CARD_NONE = 4'd0;
  localparam card_t CARD_ACE  = 4'd1;
  localparam card_t CARD_KING = 4'd13;

  // Active-low segments, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_ACE   = 7'b0001000;
  localparam logic [6:0] SEG_TWO   = 7'b0100100;
  localparam logic [6:0] SEG_THREE = 7'b0110000;
  localparam logic [6:0] SEG_FOUR  = 7'b0011001;
  localparam logic [6:0] SEG_FIVE  = 7'b0010010;
  localparam logic [6:0] SEG_SIX   = 7'b0000010;
  localparam logic [6:0] SEG_SEVEN = 7'b1111000;
  localparam logic [6:0] SEG_EIGHT = 7'b0000000;
  localparam logic [6:0] SEG_NINE  = 7'b0010000;
  localparam logic [6:0] SEG_TEN   = 7'b1000000;
  localparam logic [6:0] SEG_JACK  = 7'b1100001;
  localparam logic [6:0] SEG_QUEEN = 7'b0011000;
  localparam logic [6:0] SEG_KING  = 7'b0001001;

  // Tens and face cards (and the empty slot) count as zero.
  function automatic card_t card_value(input card_t card);
    if (card >= CARD_ACE && card <= 4'd9)
      return card;
    return 4'd0;
  endfunction

  // Sum of three card values never exceeds 27, so two compares suffice.
  function automatic logic [3:0] score_mod10(input logic [4:0] sum);
    logic [4:0] r;
    if (sum >= 5'd20)
      r = sum - 5'd20;
    else if (sum >= 5'd10)
      r = sum - 5'd10;
    else
      r = sum;
    return r[3:0];
  endfunction

endpackage

// File: rtl/baccarat_card7seg.sv
// Seven-segment decoder for one card slot; 0 and 14..15 show blank.
module card7seg
  import baccarat_pkg::*;
(
  input  logic [3:0] card,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (card)
      4'd1:    seg = SEG_ACE;
      4'd2:    seg = SEG_TWO;
      4'd3:    seg = SEG_THREE;
      4'd4:    seg = SEG_FOUR;
      4'd5:    seg = SEG_FIVE;
      4'd6:    seg = SEG_SIX;
      4'd7:    seg = SEG_SEVEN;
      4'd8:    seg = SEG_EIGHT;
      4'd9:    seg = SEG_NINE;
      4'd10:   seg = SEG_TEN;
      4'd11:   seg = SEG_JACK;
      4'd12:   seg = SEG_QUEEN;
      4'd13:   seg = SEG_KING;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/baccarat_datapath.sv
// Baccarat card datapath: free-running card counter, deal-button edge detect,
// six card registers, scores and HEX drivers. Define SLOW_SYNC_EN to add a
// 2-flop synchronizer on slow_clock and the load strobes.
module baccarat_datapath
  import baccarat_pkg::*;
(
  input  logic       fast_clock,
  input  logic       resetb,
  input  logic       slow_clock,
  input  logic       load_pcard1,
  input  logic       load_pcard2,
  input  logic       load_pcard3,
  input  logic       load_dcard1,
  input  logic       load_dcard2,
  input  logic       load_dcard3,
  output logic [3:0] pcard3_out,
  output logic [3:0] pscore_out,
  output logic [3:0] dscore_out,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5
);

  // Slot order: 0..2 player cards 1..3, 3..5 dealer cards 1..3.
  logic [NUM_CARDS-1:0] load_raw;
  logic [NUM_CARDS-1:0] load_level;
  logic                 slow_level;
  logic                 slow_prev;
  logic                 load_event;
  card_t                card_count;
  card_t                cards [NUM_CARDS];
  logic [6:0]           hex [NUM_CARDS];
  logic [4:0]           psum;
  logic [4:0]           dsum;

  assign load_raw = {load_dcard3, load_dcard2, load_dcard1,
                     load_pcard3, load_pcard2, load_pcard1};

`ifdef SLOW_SYNC_EN
  // Button and strobes share one synchronizer so they stay aligned.
  logic [NUM_CARDS:0] sync_stage1;
  logic [NUM_CARDS:0] sync_stage2;

  always_ff @(posedge fast_clock or negedge resetb) begin
    if (!resetb) begin
      sync_stage1 <= '0;
      sync_stage2 <= '0;
    end else begin
      sync_stage1 <= {slow_clock, load_raw};
      sync_stage2 <= sync_stage1;
    end
  end

  assign slow_level = sync_stage2[NUM_CARDS];
  assign load_level = sync_stage2[NUM_CARDS-1:0];
`else
  assign slow_level = slow_clock;
  assign load_level = load_raw;
`endif

  assign load_event = slow_level & ~slow_prev;

  // Any out-of-range value falls back to ace so the counter self-recovers.
  always_ff @(posedge fast_clock or negedge resetb) begin
    if (!resetb) begin
      card_count <= CARD_ACE;
      slow_prev  <= 1'b0;
    end else begin
      slow_prev <= slow_level;
      if (card_count >= CARD_KING || card_count == CARD_NONE)
        card_count <= CARD_ACE;
      else
        card_count <= card_count + 4'd1;
    end
  end

  always_ff @(posedge fast_clock or negedge resetb) begin
    if (!resetb) begin
      for (int i = 0; i < NUM_CARDS; i++)
        cards[i] <= CARD_NONE;
    end else if (load_event) begin
      for (int i = 0; i < NUM_CARDS; i++)
        if (load_level[i])
          cards[i] <= card_count;
    end
  end

  assign psum = 5'(card_value(cards[0])) + 5'(card_value(cards[1])) + 5'(card_value(cards[2]));
  assign dsum = 5'(card_value(cards[3])) + 5'(card_value(cards[4])) + 5'(card_value(cards[5]));

  assign pscore_out = score_mod10(psum);
  assign dscore_out = score_mod10(dsum);
  assign pcard3_out = cards[2];

  generate
    for (genvar gi = 0; gi < NUM_CARDS; gi++) begin : g_seg
      card7seg u_card7seg (
        .card (cards[gi]),
        .seg  (hex[gi])
      );
    end
  endgenerate

  assign HEX0 = hex[0];
  assign HEX1 = hex[1];
  assign HEX2 = hex[2];
  assign HEX3 = hex[3];
  assign HEX4 = hex[4];
  assign HEX5 = hex[5];

endmodule

// File: tb/tb_baccarat_datapath.sv
// Scoreboard bench for baccarat_datapath: stimulus pushes expected card sets,
// a negedge monitor pops and compares once the load should be visible.
module tb_baccarat_datapath;

`ifdef SLOW_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       fast_clock = 1'b0;
  logic       resetb = 1'b0;
  logic       slow_clock = 1'b0;
  logic       load_pcard1 = 1'b0, load_pcard2 = 1'b0, load_pcard3 = 1'b0;
  logic       load_dcard1 = 1'b0, load_dcard2 = 1'b0, load_dcard3 = 1'b0;
  logic [3:0] pcard3_out, pscore_out, dscore_out;
  logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

  baccarat_datapath dut (
    .fast_clock  (fast_clock),
    .resetb      (resetb),
    .slow_clock  (slow_clock),
    .load_pcard1 (load_pcard1),
    .load_pcard2 (load_pcard2),
    .load_pcard3 (load_pcard3),
    .load_dcard1 (load_dcard1),
    .load_dcard2 (load_dcard2),
    .load_dcard3 (load_dcard3),
    .pcard3_out  (pcard3_out),
    .pscore_out  (pscore_out),
    .dscore_out  (dscore_out),
    .HEX0        (HEX0),
    .HEX1        (HEX1),
    .HEX2        (HEX2),
    .HEX3        (HEX3),
    .HEX4        (HEX4),
    .HEX5        (HEX5)
  );

  always #5 fast_clock = ~fast_clock;

  // Number of rising edges seen since reset release.
  int edge_idx = 0;
  always @(posedge fast_clock) begin
    if (!resetb) edge_idx = 0;
    else         edge_idx = edge_idx + 1;
  end

  typedef struct packed {
    int          check_at;
    logic [23:0] cards;
  } exp_t;

  exp_t       sb[$];
  int         model[6];
  logic [6:0] seg_tab[16];
  int         total = 0;
  int         bad = 0;

  function automatic int val(input int c);
    return (c >= 1 && c <= 9) ? c : 0;
  endfunction

  function automatic logic [23:0] snap();
    logic [23:0] r;
    for (int i = 0; i < 6; i++) r[4*i +: 4] = 4'(model[i]);
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [23:0] c);
    int         cv[6];
    logic [6:0] hx[6];
    hx[0] = HEX0; hx[1] = HEX1; hx[2] = HEX2;
    hx[3] = HEX3; hx[4] = HEX4; hx[5] = HEX5;
    for (int i = 0; i < 6; i++) cv[i] = int'(c[4*i +: 4]);
    chk({tag, ".pcard3"}, int'(pcard3_out), cv[2]);
    chk({tag, ".pscore"}, int'(pscore_out), (val(cv[0]) + val(cv[1]) + val(cv[2])) % 10);
    chk({tag, ".dscore"}, int'(dscore_out), (val(cv[3]) + val(cv[4]) + val(cv[5])) % 10);
    for (int i = 0; i < 6; i++)
      chk($sformatf("%s.hex%0d", tag, i), int'(hx[i]), int'(seg_tab[cv[i]]));
    $display("txn %s cards p=%0d,%0d,%0d d=%0d,%0d,%0d score p=%0d d=%0d",
             tag, cv[0], cv[1], cv[2], cv[3], cv[4], cv[5], pscore_out, dscore_out);
  endtask

  // Monitor: compares when the queued expectation falls due.
  always @(negedge fast_clock) begin
    if (resetb && sb.size() > 0) begin
      if (sb[0].check_at == edge_idx) begin
        exp_t e;
        e = sb.pop_front();
        check_outputs($sformatf("edge%0d", e.check_at), e.cards);
      end else if (sb[0].check_at < edge_idx) begin
        exp_t e;
        e = sb.pop_front();
        chk("scoreboard_late", edge_idx, e.check_at);
      end
    end
  end

  task automatic set_loads(input logic [5:0] m);
    {load_dcard3, load_dcard2, load_dcard1, load_pcard3, load_pcard2, load_pcard1} = m;
  endtask

  task automatic push_now();
    sb.push_back('{check_at: edge_idx + LAT + 1, cards: snap()});
  endtask

  // Called at a negedge; the counter value captured is the one the
  // event edge sees, i.e. (event edge index mod 13) + 1.
  task automatic pulse(input logic [5:0] mask, input int hold);
    int v;
    int h;
    v = ((edge_idx + LAT) % 13) + 1;
    for (int i = 0; i < 6; i++) if (mask[i]) model[i] = v;
    push_now();
    h = (hold < LAT + 1) ? LAT + 1 : hold;
    slow_clock = 1'b1;
    set_loads(mask);
    repeat (h) @(negedge fast_clock);
    slow_clock = 1'b0;
    set_loads(6'b0);
    repeat (LAT + 2) @(negedge fast_clock);
  endtask

  task automatic wait_for(input int v);
    int n = 0;
    while ((((edge_idx + LAT) % 13) + 1) != v && n < 20) begin
      @(negedge fast_clock);
      n++;
    end
  endtask

  task automatic do_reset();
    resetb = 1'b0;
    for (int i = 0; i < 6; i++) model[i] = 0;
    repeat (3) @(negedge fast_clock);
    check_outputs("reset", 24'h0);
    resetb = 1'b1;
  endtask

  initial begin
    seg_tab[0]  = 7'b1111111; seg_tab[1]  = 7'b0001000; seg_tab[2]  = 7'b0100100;
    seg_tab[3]  = 7'b0110000; seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010;
    seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000; seg_tab[8]  = 7'b0000000;
    seg_tab[9]  = 7'b0010000; seg_tab[10] = 7'b1000000; seg_tab[11] = 7'b1100001;
    seg_tab[12] = 7'b0011000; seg_tab[13] = 7'b0001001; seg_tab[14] = 7'b1111111;
    seg_tab[15] = 7'b1111111;

    do_reset();

    // Counter sequence 1..13 then wrap to 1, observed through player card 3.
    for (int v = 1; v <= 14; v++) begin
      wait_for(((v - 1) % 13) + 1);
      pulse(6'b000100, LAT + 1);
    end

    do_reset();
    wait_for(7);  pulse(6'b000001, LAT + 1);
    wait_for(8);  pulse(6'b000010, LAT + 1);
    wait_for(13); pulse(6'b001000, LAT + 1);
    wait_for(5);  pulse(6'b010000, LAT + 1);
    wait_for(12); pulse(6'b000100, LAT + 1);

    // Long button hold: exactly one capture.
    wait_for(3);
    pulse(6'b100000, LAT + 5);
    push_now();
    repeat (LAT + 2) @(negedge fast_clock);

    // Strobes without a button edge must not load.
    set_loads(6'b111111);
    push_now();
    repeat (LAT + 3) @(negedge fast_clock);
    set_loads(6'b0);
    repeat (LAT + 2) @(negedge fast_clock);

    wait_for(9);
    pulse(6'b111111, LAT + 1);

    for (int k = 0; k < 60; k++) begin
      repeat ($urandom_range(0, 5)) @(negedge fast_clock);
      pulse(6'($urandom_range(0, 63)), LAT + 1 + int'($urandom_range(0, 4)));
    end

    begin
      int n = 0;
      while (sb.size() > 0 && n < 100) begin
        @(negedge fast_clock);
        n++;
      end
      chk("drain", sb.size(), 0);
    end

    // Asynchronous reset between clock edges.
    @(posedge fast_clock);
    #2 resetb = 1'b0;
    #1 check_outputs("async_reset", 24'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
